// File: rtl/final_project_pixel_engine.sv
// Box pixel engine for a 160x120 frame: draws, moves and clears a BOX x BOX
// square, issuing at most one registered pixel write per clock.
module final_project_pixel_engine #(
  parameter int TICK_DIV = 833333,
  parameter int BOX      = 4,
  parameter int X0       = 78,
  parameter int Y0       = 58
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_draw,
  input  logic       en_play,
  input  logic       en_erase,
  input  logic [3:0] dir,
  input  logic [2:0] pen_color,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam int TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TICK_LAST_I = TICK_DIV - 1;
  localparam int ONE_I       = 1;
  localparam logic [TW-1:0] TICK_LAST = TICK_LAST_I[TW-1:0];
  localparam logic [TW-1:0] TICK_ONE  = ONE_I[TW-1:0];
  localparam logic [7:0] X_MAX      = 8'(160 - BOX);
  localparam logic [6:0] Y_MAX      = 7'(120 - BOX);
  localparam logic [7:0] BX_LAST    = 8'(BOX - 1);
  localparam logic [6:0] BY_LAST    = 7'(BOX - 1);
  localparam logic [7:0] X_HOME     = 8'(X0);
  localparam logic [6:0] Y_HOME     = 7'(Y0);
  localparam logic [7:0] SCR_X_LAST = 8'd159;
  localparam logic [6:0] SCR_Y_LAST = 7'd119;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BOX     = 3'd1,
    S_MOVE_ER = 3'd2,
    S_MOVE_DR = 3'd3,
    S_CLEAR   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    px_q, px_d, tx_q, tx_d, cx_q, cx_d;
  logic [6:0]    py_q, py_d, ty_q, ty_d, cy_q, cy_d;
  logic          drawn_q, drawn_d, pend_q, pend_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    col_q, col_d;
  logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [7:0]    tgt_x;
  logic [6:0]    tgt_y;
  logic          wrap, box_last, clr_last;

  // Clamped one-pixel target; opposing requests on an axis cancel.
  always_comb begin
    tgt_x = px_q;
    tgt_y = py_q;
    if (dir[3] && !dir[2] && (py_q != 7'd0)) begin
      tgt_y = py_q - 7'd1;
    end else if (dir[2] && !dir[3] && (py_q < Y_MAX)) begin
      tgt_y = py_q + 7'd1;
    end else begin
      tgt_y = py_q;
    end
    if (dir[1] && !dir[0] && (px_q != 8'd0)) begin
      tgt_x = px_q - 8'd1;
    end else if (dir[0] && !dir[1] && (px_q < X_MAX)) begin
      tgt_x = px_q + 8'd1;
    end else begin
      tgt_x = px_q;
    end
  end

  // Next-state logic: sequencing, scan counters, position and flags.
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    drawn_d  = drawn_q;
    pend_d   = en_erase ? 1'b1 : pend_q;
    tick_d   = tick_q;
    wrap     = 1'b0;
    box_last = (cx_q == BX_LAST) && (cy_q == BY_LAST);
    clr_last = (cx_q == SCR_X_LAST) && (cy_q == SCR_Y_LAST);

    // Tick divider only advances while idling in play mode; it holds otherwise.
    if ((state_q == S_IDLE) && en_play) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        wrap   = 1'b1;
      end else begin
        tick_d = tick_q + TICK_ONE;
      end
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE: begin
        cx_d = 8'd0;
        cy_d = 7'd0;
        if (pend_q) begin
          state_d = S_CLEAR;
          pend_d  = 1'b0;
        end else if (en_draw && !en_play && !drawn_q) begin
          state_d = S_BOX;
          drawn_d = 1'b1;
        end else if (wrap && ((tgt_x != px_q) || (tgt_y != py_q))) begin
          state_d = S_MOVE_ER;
          tx_d    = tgt_x;
          ty_d    = tgt_y;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BOX, S_MOVE_ER, S_MOVE_DR: begin
        if (box_last) begin
          cx_d = 8'd0;
          cy_d = 7'd0;
          if (state_q == S_MOVE_ER) begin
            state_d = S_MOVE_DR;
            px_d    = tx_q;
            py_d    = ty_q;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cx_q == BX_LAST) begin
          cx_d = 8'd0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_CLEAR: begin
        if (clr_last) begin
          state_d = S_DONE;
          cx_d    = 8'd0;
          cy_d    = 7'd0;
        end else if (cx_q == SCR_X_LAST) begin
          cx_d = 8'd0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        px_d    = X_HOME;
        py_d    = Y_HOME;
        drawn_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pixel output stage: one pipeline step behind the scanning state.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    col_d  = col_q;
    plot_d = 1'b0;
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_DONE);
    case (state_q)
      S_BOX, S_MOVE_DR: begin
        x_d    = px_q + cx_q;
        y_d    = py_q + cy_q;
        col_d  = pen_color;
        plot_d = 1'b1;
      end
      S_MOVE_ER: begin
        x_d    = px_q + cx_q;
        y_d    = py_q + cy_q;
        col_d  = 3'b000;
        plot_d = 1'b1;
      end
      S_CLEAR: begin
        x_d    = cx_q;
        y_d    = cy_q;
        col_d  = 3'b000;
        plot_d = 1'b1;
      end
      default: begin
        plot_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      px_q    <= X_HOME;
      py_q    <= Y_HOME;
      tx_q    <= X_HOME;
      ty_q    <= Y_HOME;
      cx_q    <= 8'd0;
      cy_q    <= 7'd0;
      drawn_q <= 1'b0;
      pend_q  <= 1'b0;
      tick_q  <= '0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      col_q   <= 3'b000;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      drawn_q <= drawn_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vga_x     = x_q;
  assign vga_y     = y_q;
  assign vga_color = col_q;
  assign vga_plot  = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
